// File: rtl/fp32_to_int_conv.sv
// Three-stage elastic IEEE-754 single -> signed OUT_W-bit integer converter.
// Define FP2INT_RNE_EN for round-to-nearest-even; default build truncates toward zero.
module fp32_to_int_conv #(
    parameter int unsigned OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      a,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] result,
    output logic [4:0]       flags,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_DENORM,
        CLS_NAN,
        CLS_INF,
        CLS_NORM
    } cls_t;

    localparam logic signed [8:0] K_BIG   = 9'(OUT_W);
    localparam logic [OUT_W:0]    MAG_LIM = {2'b01, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0]  MAX_POS = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0]  MIN_NEG = {1'b1, {(OUT_W-1){1'b0}}};

    // handshake
    logic s1_valid, s2_valid, s3_valid;
    logic s1_adv, s2_adv, s3_adv;
    logic s2_free, s3_free;
    logic accept;

    always_comb begin
        s3_adv   = s3_valid & out_ready;
        s3_free  = ~s3_valid | s3_adv;
        s2_adv   = s2_valid & s3_free;
        s2_free  = ~s2_valid | s2_adv;
        s1_adv   = s1_valid & s2_free;
        in_ready = ~s1_valid | s1_adv;
        accept   = in_valid & in_ready;
    end

    assign out_valid = s3_valid;

    // S1: unpack and classify
    logic              s1_sign;
    logic [23:0]       s1_m;
    logic signed [8:0] s1_k;
    cls_t              s1_cls;
    cls_t              in_cls;

    always_comb begin
        if (a[30:23] == 8'd0) begin
            in_cls = (a[22:0] == 23'd0) ? CLS_ZERO : CLS_DENORM;
        end else if (a[30:23] == 8'hFF) begin
            in_cls = (a[22:0] == 23'd0) ? CLS_INF : CLS_NAN;
        end else begin
            in_cls = CLS_NORM;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_m     <= '0;
            s1_k     <= '0;
            s1_cls   <= CLS_ZERO;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
            if (accept) begin
                s1_sign <= a[31];
                s1_m    <= {a[30:23] != 8'd0, a[22:0]};
                s1_k    <= $signed({1'b0, a[30:23]}) - 9'sd127;
                s1_cls  <= in_cls;
            end
        end
    end

    // S2: align. Treating m as a fixed-point value with 23 fraction bits and
    // shifting left by k puts the integer part at [OUT_W+22:23] and leaves
    // guard/sticky in the low bits, covering both k>=23 and 0<=k<23.
    logic [OUT_W+22:0] shifted;
    logic [OUT_W:0]    al_mag;
    logic              al_guard;
    logic              al_sticky;

    always_comb begin
        shifted   = {{(OUT_W-1){1'b0}}, s1_m} << s1_k[4:0];
        al_mag    = '0;
        al_guard  = 1'b0;
        al_sticky = 1'b0;
        if (s1_cls == CLS_NORM) begin
            if (s1_k >= K_BIG) begin
                // |value| >= 2^OUT_W: top bit alone marks overflow for both signs
                al_mag = {1'b1, {OUT_W{1'b0}}};
            end else if (!s1_k[8]) begin
                al_mag    = {1'b0, shifted[OUT_W+22:23]};
                al_guard  = shifted[22];
                al_sticky = |shifted[21:0];
            end else if (s1_k == 9'h1FF) begin
                al_guard  = 1'b1;
                al_sticky = |s1_m[22:0];
            end else begin
                al_sticky = 1'b1;
            end
        end
    end

    logic           s2_sign;
    logic [OUT_W:0] s2_mag;
    logic           s2_guard;
    logic           s2_sticky;
    cls_t           s2_cls;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid  <= 1'b0;
            s2_sign   <= 1'b0;
            s2_mag    <= '0;
            s2_guard  <= 1'b0;
            s2_sticky <= 1'b0;
            s2_cls    <= CLS_ZERO;
        end else begin
            if (s1_adv) begin
                s2_valid <= 1'b1;
            end else if (s2_adv) begin
                s2_valid <= 1'b0;
            end
            if (s1_adv) begin
                s2_sign   <= s1_sign;
                s2_mag    <= al_mag;
                s2_guard  <= al_guard;
                s2_sticky <= al_sticky;
                s2_cls    <= s1_cls;
            end
        end
    end

    // S3: round, negate, saturate
    logic [OUT_W:0]   mag_r;
    logic             ovf;
    logic [OUT_W-1:0] rd_result;
    logic [4:0]       rd_flags;

    always_comb begin
`ifdef FP2INT_RNE_EN
        mag_r = s2_mag + {{OUT_W{1'b0}}, s2_guard & (s2_sticky | s2_mag[0])};
`else
        mag_r = s2_mag;
`endif
        ovf       = s2_sign ? (mag_r > MAG_LIM) : (mag_r >= MAG_LIM);
        rd_result = '0;
        rd_flags  = '0;
        case (s2_cls)
            CLS_NAN: begin
                rd_result = MAX_POS;
                rd_flags  = 5'h10;
            end
            CLS_INF: begin
                rd_result = s2_sign ? MIN_NEG : MAX_POS;
                rd_flags  = 5'h10;
            end
            CLS_DENORM: begin
                rd_flags = 5'h01;
            end
            CLS_NORM: begin
                if (ovf) begin
                    rd_result = s2_sign ? MIN_NEG : MAX_POS;
                    rd_flags  = 5'h10;
                end else begin
                    rd_result = s2_sign ? ('0 - mag_r[OUT_W-1:0]) : mag_r[OUT_W-1:0];
                    rd_flags  = {4'b0000, s2_guard | s2_sticky};
                end
            end
            default: begin
                rd_result = '0;
                rd_flags  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s3_valid <= 1'b0;
            result   <= '0;
            flags    <= '0;
        end else begin
            if (s2_adv) begin
                s3_valid <= 1'b1;
            end else if (s3_adv) begin
                s3_valid <= 1'b0;
            end
            if (s2_adv) begin
                result <= rd_result;
                flags  <= rd_flags;
            end
        end
    end

endmodule
